// File: rtl/shift_mul_ctrl_pkg.sv
// Shared constants and FSM state encoding for the shift-add multiply-add sequencer.
package shift_mul_ctrl_pkg;

    localparam int MUL_W     = 16;
    localparam int MUL_DW    = 2 * MUL_W;
    localparam int MUL_CNT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ADD   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/shift_mul_ctrl_if.sv
// Request/response and shift-register control bundle of the multiply-add sequencer.
interface shift_mul_ctrl_if
    import shift_mul_ctrl_pkg::*;
#(
    parameter int W = MUL_W
);
    logic           start;
    logic           abort;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [W-1:0]   op_c;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic [2*W-1:0] sr_d;
    logic           sr_srin;
    logic           sr_we;
    logic           sr_sr;
    logic [2*W-1:0] sr_q;

    // slave = the sequencer; master = the parent that owns the decode and the shift register
    modport slave (
        input  start, abort, op_a, op_b, op_c, sr_q,
        output busy, done, result, sr_d, sr_srin, sr_we, sr_sr
    );

    modport master (
        output start, abort, op_a, op_b, op_c, sr_q,
        input  busy, done, result, sr_d, sr_srin, sr_we, sr_sr
    );
endinterface

// File: rtl/shift_mul_ctrl_adder.sv
// Combinational W+W -> W+1 adder used to accumulate the multiplicand into ACC.
module shift_mul_ctrl_adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   sum
);
    assign sum = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/shift_mul_ctrl.sv
// Sequencer for iterative unsigned multiply-add (a*b + c) over an external right-shift register.
// Optional macro MUL_ZERO_SKIP_EN: skip the ADD step for zero multiplier bits (variable latency).
module shift_mul_ctrl
    import shift_mul_ctrl_pkg::*;
#(
    parameter int W     = MUL_W,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_mul_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    state_t           state_reg, state_next;
    logic [W-1:0]     a_reg, b_reg, c_reg;
    logic             carry_reg, carry_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [W:0]       sum;

    logic             busy_c, done_c, sr_we_c, sr_sr_c, sr_srin_c;
    logic [2*W-1:0]   sr_d_c;

    shift_mul_ctrl_adder #(.W(W)) u_adder (
        .a   (bus.sr_q[2*W-1:W]),
        .b   (b_reg),
        .sum (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            c_reg     <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            carry_reg <= carry_next;
            cnt_reg   <= cnt_next;
            if (state_reg == ST_IDLE && bus.start) begin
                a_reg <= bus.op_a;
                b_reg <= bus.op_b;
                c_reg <= bus.op_c;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        carry_next = carry_reg;
        cnt_next   = cnt_reg;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        sr_we_c    = 1'b0;
        sr_sr_c    = 1'b0;
        sr_srin_c  = 1'b0;
        sr_d_c     = '0;
        unique case (state_reg)
            ST_IDLE: begin
                // start wins over a simultaneous abort here
                if (bus.start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                busy_c = 1'b1;
                if (bus.abort) begin
                    state_next = ST_IDLE;
                end else begin
                    sr_we_c  = 1'b1;
                    sr_d_c   = {c_reg, a_reg};
                    cnt_next = '0;
`ifdef MUL_ZERO_SKIP_EN
                    if (a_reg[0]) begin
                        state_next = ST_ADD;
                    end else begin
                        state_next = ST_SHIFT;
                        carry_next = 1'b0;
                    end
`else
                    state_next = ST_ADD;
`endif
                end
            end
            ST_ADD: begin
                busy_c = 1'b1;
                if (bus.abort) begin
                    state_next = ST_IDLE;
                end else begin
                    if (bus.sr_q[0]) begin
                        sr_we_c    = 1'b1;
                        sr_d_c     = {sum[W-1:0], bus.sr_q[W-1:0]};
                        carry_next = sum[W];
                    end else begin
                        carry_next = 1'b0;
                    end
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy_c = 1'b1;
                if (bus.abort) begin
                    state_next = ST_IDLE;
                end else begin
                    sr_we_c   = 1'b1;
                    sr_sr_c   = 1'b1;
                    sr_srin_c = carry_reg;
                    cnt_next  = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_LAST) begin
                        state_next = ST_DONE;
                    end else begin
`ifdef MUL_ZERO_SKIP_EN
                        // bit 1 becomes the multiplier LSB once this shift lands
                        if (bus.sr_q[1]) begin
                            state_next = ST_ADD;
                        end else begin
                            state_next = ST_SHIFT;
                            carry_next = 1'b0;
                        end
`else
                        state_next = ST_ADD;
`endif
                    end
                end
            end
            ST_DONE: begin
                done_c     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.busy    = busy_c;
    assign bus.done    = done_c;
    assign bus.sr_we   = sr_we_c;
    assign bus.sr_sr   = sr_sr_c;
    assign bus.sr_srin = sr_srin_c;
    assign bus.sr_d    = sr_d_c;
    assign bus.result  = bus.sr_q;

endmodule

// File: tb/tb_shift_mul_ctrl.sv
// Scoreboard bench for shift_mul_ctrl together with a behavioural 32-bit right-shift register.
module tb_shift_mul_ctrl;
    import shift_mul_ctrl_pkg::*;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          writes;
        int          accept;
    } exp_t;

    logic clk;
    logic rst_n;
    int   edge_cnt;
    int   n_checks;
    int   n_fail;
    int   we_cnt;
    exp_t sb[$];

    shift_mul_ctrl_if #(.W(MUL_W)) bus_if ();

    shift_mul_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Shift register shares the reset with the sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus_if.sr_q <= '0;
        else if (bus_if.sr_we)
            bus_if.sr_q <= bus_if.sr_sr ? {bus_if.sr_srin, bus_if.sr_q[31:1]} : bus_if.sr_d;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        edge_cnt = 0;
        forever begin
            @(posedge clk);
            edge_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_latency(input logic [15:0] a);
`ifdef MUL_ZERO_SKIP_EN
        return 18 + $countones(a);
`else
        return 34;
`endif
    endfunction

    // Monitor: pops the scoreboard whenever the DUT signals done
    initial begin
        exp_t e;
        we_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus_if.done) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_done: got done=1 with result %h, expected no done", bus_if.result);
                    end else begin
                        e = sb.pop_front();
                        $display("done: result=%h latency=%0d writes=%0d", bus_if.result, edge_cnt - e.accept + 1, we_cnt);
                        check("result", bus_if.result, e.res);
                        // the consumer captures done on the following rising edge
                        check("latency", 32'(edge_cnt - e.accept + 1), 32'(e.lat));
                        check("sr_we_count", 32'(we_cnt), 32'(e.writes));
                        check("busy_in_done", {31'd0, bus_if.busy}, 32'd0);
                    end
                    we_cnt = 0;
                end else if (bus_if.busy) begin
                    if (bus_if.sr_we) we_cnt++;
                end else begin
                    we_cnt = 0;
                end
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input logic [31:0] res, input bit expect_done, input bit with_abort,
                         output int acc_edge);
        exp_t e;
        @(negedge clk);
        bus_if.op_a  = a;
        bus_if.op_b  = b;
        bus_if.op_c  = c;
        bus_if.start = 1'b1;
        bus_if.abort = with_abort;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        acc_edge = edge_cnt;
        $display("issue: a=%h b=%h c=%h expect_done=%0d", a, b, c, expect_done);
        if (expect_done) begin
            e.res    = res;
            e.lat    = exp_latency(a);
            e.writes = 1 + 16 + $countones(a);
            e.accept = acc_edge;
            sb.push_back(e);
        end
    endtask

    task automatic wait_sb_empty(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending results, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation time %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        bus_if.op_a  = '0;
        bus_if.op_b  = '0;
        bus_if.op_c  = '0;

        // Reset state
        #12;
        check("rst_busy",   {31'd0, bus_if.busy},    32'd0);
        check("rst_done",   {31'd0, bus_if.done},    32'd0);
        check("rst_sr_we",  {31'd0, bus_if.sr_we},   32'd0);
        check("rst_sr_sr",  {31'd0, bus_if.sr_sr},   32'd0);
        check("rst_sr_srin",{31'd0, bus_if.sr_srin}, 32'd0);
        check("rst_sr_d",   bus_if.sr_d,             32'd0);
        check("rst_result", bus_if.result,           32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: small product, then busy must be low
        issue(16'h0003, 16'h0005, 16'h0000, 32'h0000000F, 1'b1, 1'b0, acc);
        wait_sb_empty("t1");
        #1;
        check("t1_busy_after", {31'd0, bus_if.busy}, 32'd0);

        // 2: all ones, carry into srin every step
        issue(16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF0000, 1'b1, 1'b0, acc);
        wait_sb_empty("t2");

        // 3: zero multiplier, addend passes through; sr_we count excludes every ADD
        issue(16'h0000, 16'h1234, 16'hABCD, 32'h0000ABCD, 1'b1, 1'b0, acc);
        wait_sb_empty("t3");

        // 4a: start re-pulsed mid-operation must be ignored
        issue(16'h00FF, 16'h0101, 16'h0002, 32'h00010001, 1'b1, 1'b0, acc);
        repeat (9) @(posedge clk);
        #1;
        bus_if.op_a  = 16'h0001;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        wait_sb_empty("t4a");
        repeat (40) @(posedge clk);

        // 4b: abort at edge +12
        issue(16'hAAAA, 16'h5555, 16'h1111, 32'h0, 1'b0, 1'b0, acc);
        repeat (11) @(posedge clk);
        #1;
        bus_if.abort = 1'b1;
        @(negedge clk);
        check("abort_sr_we", {31'd0, bus_if.sr_we}, 32'd0);
        check("abort_busy_during", {31'd0, bus_if.busy}, 32'd1);
        @(posedge clk);
        #1;
        bus_if.abort = 1'b0;
        check("abort_busy_after", {31'd0, bus_if.busy}, 32'd0);
        repeat (40) @(posedge clk);

        // abort together with start in IDLE: start wins
        issue(16'h0002, 16'h0007, 16'h0003, 32'h00000011, 1'b1, 1'b1, acc);
        wait_sb_empty("t4c");

        // 5: reset at edge +20 of a running operation
        issue(16'hF0F0, 16'h1111, 16'h0000, 32'h0, 1'b0, 1'b0, acc);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  {31'd0, bus_if.busy},  32'd0);
        check("mid_rst_done",  {31'd0, bus_if.done},  32'd0);
        check("mid_rst_sr_we", {31'd0, bus_if.sr_we}, 32'd0);
        check("mid_rst_sr_q",  bus_if.sr_q,           32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'h1234, 16'h5678, 16'h9ABC, 32'h06269B1C, 1'b1, 1'b0, acc);
        wait_sb_empty("t5");

        // 6: sparse multiplier (latency 20 with zero-skip, 34 without)
        issue(16'h8001, 16'h0002, 16'h0001, 32'h00010003, 1'b1, 1'b0, acc);
        wait_sb_empty("t6");

        repeat (40) @(posedge clk);
        check("pending_results", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
